// File: rtl/fft_bf_if.sv
// Sample-RAM and twiddle-ROM bus between the FFT butterfly engine and its memories.
// The master side is the engine; the slave side is the RAM/ROM/controller.
interface fft_bf_if #(
  parameter int N_LOG2 = 9,
  parameter int WIDTH  = 32,
  parameter int ADDR   = 9
);
  logic                    start;
  logic                    busy;
  logic                    done;
  logic [ADDR-1:0]         addr_0;
  logic [ADDR-1:0]         addr_1;
  logic                    wr_en_0;
  logic                    wr_en_1;
  logic [WIDTH-1:0]        wdata_0;
  logic [WIDTH-1:0]        wdata_1;
  logic [WIDTH-1:0]        rdata_0;
  logic [WIDTH-1:0]        rdata_1;
  logic [N_LOG2-2:0]       tw_addr;
  logic signed [15:0]      tw_re;
  logic signed [15:0]      tw_im;
  logic [3:0]              stage;

  modport master (
    input  start, rdata_0, rdata_1, tw_re, tw_im,
    output busy, done, addr_0, addr_1, wr_en_0, wr_en_1,
           wdata_0, wdata_1, tw_addr, stage
  );

  modport slave (
    output start, rdata_0, rdata_1, tw_re, tw_im,
    input  busy, done, addr_0, addr_1, wr_en_0, wr_en_1,
           wdata_0, wdata_1, tw_addr, stage
  );
endinterface

// File: rtl/fft_bf_engine.sv
// In-place radix-2 DIT FFT engine. Walks every stage and butterfly over a
// bit-reversed sample RAM, four cycles per butterfly (READ, LATCH, MUL, WRITE),
// scaling by 1/2 per stage, and pulses done once the last stage is written.
module fft_bf_engine #(
  parameter int N_LOG2 = 9,
  parameter int WIDTH  = 32,
  parameter int ADDR   = 9
) (
  input  logic     clk,
  input  logic     rst,
  fft_bf_if.master bus
);

  // Butterfly index width: N/2 butterflies per stage.
  localparam int         KW         = N_LOG2 - 1;
  localparam logic [3:0] LAST_STAGE = 4'(N_LOG2 - 1);
  localparam logic [3:0] KW4        = 4'(KW);
  localparam int         HALF       = WIDTH / 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LATCH = 3'd2,
    MUL   = 3'd3,
    WRITE = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [KW-1:0] k_reg;
  logic [3:0]    stage_reg;
  logic          last_k;
  logic          last_stage;

  logic signed [15:0] ar_reg, ai_reg, br_reg, bi_reg, wr_reg, wi_reg;
  logic signed [17:0] t_re_reg, t_im_reg;

  logic signed [31:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [32:0] t_re_full, t_im_full;
  logic signed [17:0] t_re_next, t_im_next;
  logic signed [18:0] s_re, s_im, d_re, d_im;

  logic [ADDR-1:0] a_addr;
  logic [ADDR-1:0] b_addr;
  logic [ADDR-1:0] span;
  logic [KW-1:0]   k_mask;
  logic [KW-1:0]   tw_idx;

  assign last_k     = &k_reg;
  assign last_stage = (stage_reg == LAST_STAGE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: fixed four-cycle butterfly, FIN after the very last write.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = READ;
      READ:    state_next = LATCH;
      LATCH:   state_next = MUL;
      MUL:     state_next = WRITE;
      WRITE:   state_next = (last_k && last_stage) ? FIN : READ;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Butterfly/stage counters; k wraps naturally, stage holds on the final
  // butterfly so FIN still reports the last stage, then clears entering IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_reg     <= '0;
      stage_reg <= '0;
    end else if (state_reg == WRITE) begin
      k_reg <= k_reg + KW'(1);
      if (last_k && !last_stage) begin
        stage_reg <= stage_reg + 4'd1;
      end
    end else if (state_reg == FIN) begin
      stage_reg <= '0;
    end
  end

  // Operand capture (RAM and ROM data are valid one cycle after READ) and
  // registering of the twiddle product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_reg   <= '0;
      ai_reg   <= '0;
      br_reg   <= '0;
      bi_reg   <= '0;
      wr_reg   <= '0;
      wi_reg   <= '0;
      t_re_reg <= '0;
      t_im_reg <= '0;
    end else if (state_reg == LATCH) begin
      ar_reg <= bus.rdata_0[WIDTH-1:HALF];
      ai_reg <= bus.rdata_0[HALF-1:0];
      br_reg <= bus.rdata_1[WIDTH-1:HALF];
      bi_reg <= bus.rdata_1[HALF-1:0];
      wr_reg <= bus.tw_re;
      wi_reg <= bus.tw_im;
    end else if (state_reg == MUL) begin
      t_re_reg <= t_re_next;
      t_im_reg <= t_im_next;
    end
  end

  // Complex product t = b*w. The difference/sum of two full-scale products
  // needs 33 bits before the Q1.15 renormalising shift.
  always_comb begin
    p_rr      = br_reg * wr_reg;
    p_ii      = bi_reg * wi_reg;
    p_ri      = br_reg * wi_reg;
    p_ir      = bi_reg * wr_reg;
    t_re_full = 33'(p_rr) - 33'(p_ii);
    t_im_full = 33'(p_ri) + 33'(p_ir);
    t_re_next = 18'(t_re_full >>> 15);
    t_im_next = 18'(t_im_full >>> 15);
  end

  // Butterfly sums in 19 bits; the >>>1 floor-halving keeps results in 16 bits.
  always_comb begin
    s_re = 19'(ar_reg) + 19'(t_re_reg);
    s_im = 19'(ai_reg) + 19'(t_im_reg);
    d_re = 19'(ar_reg) - 19'(t_re_reg);
    d_im = 19'(ai_reg) - 19'(t_im_reg);
  end

  // Address a is k with a zero inserted at bit position 'stage'; b sets that
  // bit. The twiddle index is the low 'stage' bits of k pushed to the top.
  for (genvar gi = 0; gi < N_LOG2; gi++) begin : g_addr
    localparam logic [3:0] GI = 4'(gi);
    if (gi == 0) begin : g_lsb
      assign a_addr[gi] = (stage_reg != 4'd0) ? k_reg[0] : 1'b0;
    end else if (gi < KW) begin : g_mid
      assign a_addr[gi] = (GI < stage_reg) ? k_reg[gi] :
                          ((GI == stage_reg) ? 1'b0 : k_reg[gi-1]);
    end else begin : g_msb
      assign a_addr[gi] = (GI == stage_reg) ? 1'b0 : k_reg[gi-1];
    end
    assign span[gi] = (GI == stage_reg);
  end

  for (genvar gi = 0; gi < KW; gi++) begin : g_kmask
    localparam logic [3:0] GI = 4'(gi);
    assign k_mask[gi] = (GI < stage_reg) & k_reg[gi];
  end

  assign b_addr = a_addr | span;
  assign tw_idx = k_mask << (KW4 - stage_reg);

  // Output decode: addresses and twiddle index are held across the whole
  // butterfly, writes only in WRITE, everything else zero in IDLE and FIN.
  always_comb begin
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.addr_0  = '0;
    bus.addr_1  = '0;
    bus.wr_en_0 = 1'b0;
    bus.wr_en_1 = 1'b0;
    bus.wdata_0 = '0;
    bus.wdata_1 = '0;
    bus.tw_addr = '0;
    bus.stage   = stage_reg;
    case (state_reg)
      READ, LATCH, MUL, WRITE: begin
        bus.busy    = 1'b1;
        bus.addr_0  = a_addr;
        bus.addr_1  = b_addr;
        bus.tw_addr = tw_idx;
        if (state_reg == WRITE) begin
          bus.wr_en_0 = 1'b1;
          bus.wr_en_1 = 1'b1;
          bus.wdata_0 = {16'(s_re >>> 1), 16'(s_im >>> 1)};
          bus.wdata_1 = {16'(d_re >>> 1), 16'(d_im >>> 1)};
        end
      end
      FIN:     bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fft_bf_engine.sv
// Testbench for fft_bf_engine: an N=8 engine on a behavioural RAM/ROM with a
// stage-by-stage FFT reference model, plus an N=4 engine for the extremes case.
module tb_fft_bf_engine;

  localparam int NA = 3;
  localparam int NB = 2;
  localparam int SA = 1 << NA;
  localparam int SB = 1 << NB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_bf_if #(.N_LOG2(NA), .WIDTH(32), .ADDR(NA)) bus_a ();
  fft_bf_if #(.N_LOG2(NB), .WIDTH(32), .ADDR(NB)) bus_b ();

  fft_bf_engine #(.N_LOG2(NA), .WIDTH(32), .ADDR(NA)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  fft_bf_engine #(.N_LOG2(NB), .WIDTH(32), .ADDR(NB)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  int checks   = 0;
  int failures = 0;

  // Twiddle tables w(k) = cos(2*pi*k/N) - j*sin(2*pi*k/N), Q1.15 with +1.0 -> 0x7FFF.
  int rom_re_a [SA/2];
  int rom_im_a [SA/2];
  int rom_re_b [SB/2];
  int rom_im_b [SB/2];

  logic [31:0]   ram_a [SA];
  logic [31:0]   ram_b [SB];
  logic          load_a_en = 1'b0;
  logic [NA-1:0] load_a_addr = '0;
  logic [31:0]   load_a_data = '0;
  logic          load_b_en = 1'b0;
  logic [NB-1:0] load_b_addr = '0;
  logic [31:0]   load_b_data = '0;

  // Dual-port RAM + registered ROM models for engine A.
  always @(posedge clk) begin
    if (load_a_en) ram_a[load_a_addr] <= load_a_data;
    if (bus_a.wr_en_0) ram_a[bus_a.addr_0] <= bus_a.wdata_0;
    if (bus_a.wr_en_1) ram_a[bus_a.addr_1] <= bus_a.wdata_1;
    bus_a.rdata_0 <= ram_a[bus_a.addr_0];
    bus_a.rdata_1 <= ram_a[bus_a.addr_1];
    bus_a.tw_re   <= 16'(rom_re_a[bus_a.tw_addr]);
    bus_a.tw_im   <= 16'(rom_im_a[bus_a.tw_addr]);
  end

  // Same for engine B.
  always @(posedge clk) begin
    if (load_b_en) ram_b[load_b_addr] <= load_b_data;
    if (bus_b.wr_en_0) ram_b[bus_b.addr_0] <= bus_b.wdata_0;
    if (bus_b.wr_en_1) ram_b[bus_b.addr_1] <= bus_b.wdata_1;
    bus_b.rdata_0 <= ram_b[bus_b.addr_0];
    bus_b.rdata_1 <= ram_b[bus_b.addr_1];
    bus_b.tw_re   <= 16'(rom_re_b[bus_b.tw_addr]);
    bus_b.tw_im   <= 16'(rom_im_b[bus_b.tw_addr]);
  end

  // Record every WRITE of engine A as {stage, a, b, tw}.
  logic        cap_clr = 1'b1;
  logic [11:0] cap_rec [16];
  int          cap_n = 0;
  always @(posedge clk) begin
    if (cap_clr) begin
      cap_n <= 0;
    end else if (bus_a.wr_en_0 && cap_n < 16) begin
      cap_rec[cap_n] <= {bus_a.stage, bus_a.addr_0, bus_a.addr_1, bus_a.tw_addr};
      cap_n <= cap_n + 1;
    end
  end

  // First WRITE data of engine B.
  logic        capb_clr = 1'b1;
  logic        capb_got = 1'b0;
  logic [31:0] capb_wd0 = '0;
  logic [31:0] capb_wd1 = '0;
  always @(posedge clk) begin
    if (capb_clr) begin
      capb_got <= 1'b0;
    end else if (bus_b.wr_en_0 && !capb_got) begin
      capb_wd0 <= bus_b.wdata_0;
      capb_wd1 <= bus_b.wdata_1;
      capb_got <= 1'b1;
    end
  end

  // Port-level invariants: both write enables together, only while busy,
  // never the same word on both ports, never busy and done together.
  int viol = 0;
  always @(negedge clk) begin
    if ((bus_a.wr_en_0 !== bus_a.wr_en_1) ||
        (bus_a.wr_en_0 && !bus_a.busy) ||
        (bus_a.busy && bus_a.addr_0 == bus_a.addr_1) ||
        (bus_a.busy && bus_a.done))
      viol <= viol + 1;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end else begin
      $display("ok   %s value=%0h", nm, act);
    end
  endtask

  task automatic check_true(input string nm, input logic ok, input logic [31:0] act);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=within_tolerance", nm, act);
    end else begin
      $display("ok   %s value=%0h", nm, act);
    end
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_ctrl"}, {bus_a.busy, bus_a.done, bus_a.wr_en_0, bus_a.wr_en_1}, '0);
    check({tag, "_addr"}, {bus_a.addr_0, bus_a.addr_1, bus_a.tw_addr, bus_a.stage}, '0);
    check({tag, "_wdata"}, {bus_a.wdata_0, bus_a.wdata_1}, '0);
  endtask

  // Reference model state for engine A.
  int mre [SA];
  int mim [SA];

  function automatic int wrap16(input int x);
    logic [15:0] t;
    t = x[15:0];
    return int'($signed(t));
  endfunction

  task automatic load_a_word(input int addr, input logic [31:0] d);
    @(negedge clk);
    load_a_en   = 1'b1;
    load_a_addr = NA'(addr);
    load_a_data = d;
    mre[addr]   = int'($signed(d[31:16]));
    mim[addr]   = int'($signed(d[15:0]));
    @(negedge clk);
    load_a_en = 1'b0;
  endtask

  // Textbook in-place DIT FFT over groups of 2*half, scaled by 1/2 per stage.
  task automatic model_fft();
    int half, ia, ib, widx, tr, ti, nar, nai, nbr, nbi;
    longint pr, pi;
    for (int s = 0; s < NA; s++) begin
      half = 1 << s;
      for (int g = 0; g < SA; g += 2 * half) begin
        for (int j = 0; j < half; j++) begin
          ia   = g + j;
          ib   = ia + half;
          widx = j * (SA / (2 * half));
          pr   = longint'(mre[ib]) * rom_re_a[widx] - longint'(mim[ib]) * rom_im_a[widx];
          pi   = longint'(mre[ib]) * rom_im_a[widx] + longint'(mim[ib]) * rom_re_a[widx];
          tr   = int'(pr >>> 15);
          ti   = int'(pi >>> 15);
          nar  = wrap16((mre[ia] + tr) >>> 1);
          nai  = wrap16((mim[ia] + ti) >>> 1);
          nbr  = wrap16((mre[ia] - tr) >>> 1);
          nbi  = wrap16((mim[ia] - ti) >>> 1);
          mre[ia] = nar; mim[ia] = nai;
          mre[ib] = nbr; mim[ib] = nbi;
        end
      end
    end
  endtask

  task automatic compare_ram_a(input string tag);
    logic [15:0] er, ei;
    for (int i = 0; i < SA; i++) begin
      er = 16'(mre[i]);
      ei = 16'(mim[i]);
      check($sformatf("%s_word%0d", tag, i), ram_a[i], {er, ei});
    end
  endtask

  // Start engine A and observe 80 cycles (cycle 1 begins at the start edge).
  task automatic run_a(input bit second_start, output int busy_cnt,
                       output int done_idx, output int done_cnt);
    busy_cnt = 0; done_idx = 0; done_cnt = 0;
    @(negedge clk);
    bus_a.start = 1'b1;
    @(posedge clk);
    #1 bus_a.start = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      if (bus_a.busy) busy_cnt++;
      if (bus_a.done) begin
        done_cnt++;
        if (done_idx == 0) done_idx = i;
      end
      bus_a.start = (second_start && i == 10) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
    end
    bus_a.start = 1'b0;
  endtask

  typedef struct {
    logic [3:0]    st;
    logic [NA-1:0] a;
    logic [NA-1:0] b;
    logic [NA-2:0] tw;
  } pair_vec_t;

  typedef struct {
    int          addr;
    logic [31:0] init;
    logic [31:0] exp;
  } word_vec_t;

  pair_vec_t pairs [12];
  word_vec_t imp   [SA];

  initial begin
    int bc, di, dc, re0, im0, rv, iv;
    logic [15:0] r16, i16;
    logic ok;

    pairs[0]  = '{4'd0, 3'd0, 3'd1, 2'd0};
    pairs[1]  = '{4'd0, 3'd2, 3'd3, 2'd0};
    pairs[2]  = '{4'd0, 3'd4, 3'd5, 2'd0};
    pairs[3]  = '{4'd0, 3'd6, 3'd7, 2'd0};
    pairs[4]  = '{4'd1, 3'd0, 3'd2, 2'd0};
    pairs[5]  = '{4'd1, 3'd1, 3'd3, 2'd2};
    pairs[6]  = '{4'd1, 3'd4, 3'd6, 2'd0};
    pairs[7]  = '{4'd1, 3'd5, 3'd7, 2'd2};
    pairs[8]  = '{4'd2, 3'd0, 3'd4, 2'd0};
    pairs[9]  = '{4'd2, 3'd1, 3'd5, 2'd1};
    pairs[10] = '{4'd2, 3'd2, 3'd6, 2'd2};
    pairs[11] = '{4'd2, 3'd3, 3'd7, 2'd3};
    for (int i = 0; i < SA; i++)
      imp[i] = '{i, (i == 0) ? 32'h4000_0000 : 32'h0, 32'h0800_0000};

    rom_re_a[0] = 32767;  rom_im_a[0] = 0;
    rom_re_a[1] = 23170;  rom_im_a[1] = -23170;
    rom_re_a[2] = 0;      rom_im_a[2] = -32767;
    rom_re_a[3] = -23170; rom_im_a[3] = -23170;
    rom_re_b[0] = 32767;  rom_im_b[0] = 0;
    rom_re_b[1] = 0;      rom_im_b[1] = -32767;

    // Reset with start held high: the start must not survive the reset.
    rst = 1'b1;
    bus_a.start = 1'b1;
    bus_b.start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    check_idle_a("reset_state");
    repeat (3) @(negedge clk);
    check("start_with_rst_ignored", {bus_a.busy, bus_b.busy}, 2'b00);

    // Impulse run: address order, latency, ignored second start.
    for (int i = 0; i < SA; i++) load_a_word(imp[i].addr, imp[i].init);
    @(negedge clk); cap_clr = 1'b0;
    run_a(1'b1, bc, di, dc);
    check("busy_cycles", bc, 48);
    check("done_cycle", di, 49);
    check("done_count", dc, 1);
    check("write_count", cap_n, 12);
    for (int i = 0; i < 12; i++)
      check($sformatf("pair%0d", i), cap_rec[i],
            {pairs[i].st, pairs[i].a, pairs[i].b, pairs[i].tw});
    for (int i = 0; i < SA; i++)
      check($sformatf("impulse_word%0d", imp[i].addr), ram_a[imp[i].addr], imp[i].exp);
    check_idle_a("after_done");

    // DC input: all energy into bin 0, others near zero.
    for (int i = 0; i < SA; i++) load_a_word(i, 32'h4000_0000);
    model_fft();
    run_a(1'b0, bc, di, dc);
    check("dc_done_count", dc, 1);
    re0 = int'($signed(ram_a[0][31:16]));
    im0 = int'($signed(ram_a[0][15:0]));
    ok = (re0 >= 16384 - 3) && (re0 <= 16384) && (im0 >= -2) && (im0 <= 2);
    check_true("dc_bin0", ok, ram_a[0]);
    for (int i = 1; i < SA; i++) begin
      r16 = ram_a[i][31:16];
      i16 = ram_a[i][15:0];
      rv = int'($signed(r16));
      iv = int'($signed(i16));
      ok = (rv >= -2) && (rv <= 2) && (iv >= -2) && (iv <= 2);
      check_true($sformatf("dc_bin%0d", i), ok, ram_a[i]);
    end
    compare_ram_a("dc_model");

    // Random inputs against the reference model.
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < SA; i++) begin
        rv = int'($urandom_range(32766)) - 16383;
        iv = int'($urandom_range(32766)) - 16383;
        load_a_word(i, {16'(rv), 16'(iv)});
      end
      model_fft();
      run_a(1'b0, bc, di, dc);
      check($sformatf("rand%0d_done_count", t), dc, 1);
      compare_ram_a($sformatf("rand%0d", t));
    end

    // Reset in stage 1, MUL state: outputs drop immediately, no clock needed.
    @(negedge clk);
    bus_a.start = 1'b1;
    @(posedge clk);
    #1 bus_a.start = 1'b0;
    di = 0;
    for (int i = 0; i < 40 && di == 0; i++) begin
      if (bus_a.stage == 4'd1) di = 1;
      else begin @(posedge clk); #1; end
    end
    check("reach_stage1", di, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_stage_before_rst", {bus_a.busy, bus_a.wr_en_0, bus_a.stage}, {1'b1, 1'b0, 4'd1});
    rst = 1'b1;
    #1;
    check_idle_a("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < SA; i++) begin
      rv = int'($urandom_range(32766)) - 16383;
      iv = int'($urandom_range(32766)) - 16383;
      load_a_word(i, {16'(rv), 16'(iv)});
    end
    model_fft();
    run_a(1'b0, bc, di, dc);
    check("post_rst_busy_cycles", bc, 48);
    check("post_rst_done_count", dc, 1);
    compare_ram_a("post_rst");

    // Extremes on the N=4 engine: first butterfly a=b=0x8000_8000, w=0x7FFF.
    for (int i = 0; i < SB; i++) begin
      @(negedge clk);
      load_b_en = 1'b1; load_b_addr = NB'(i); load_b_data = 32'h8000_8000;
      @(negedge clk);
      load_b_en = 1'b0;
    end
    capb_clr = 1'b0;
    @(negedge clk); bus_b.start = 1'b1;
    @(negedge clk); bus_b.start = 1'b0;
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus_b.done) dc++;
      @(negedge clk);
    end
    check("ext_done_count", dc, 1);
    check("ext_captured", capb_got, 1'b1);
    check("ext_wdata_0", capb_wd0, 32'h8000_8000);
    check("ext_wdata_1", capb_wd1, 32'hFFFF_FFFF);

    check("port_invariants", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
